// File: rtl/sonar_if.sv
// Signal bundle between the sonar scheduler, its ranging engine and the result consumer.
// Engine handshake: eng_measure is a one-cycle request and the engine answers with a one-cycle
// eng_valid carrying eng_ticks; eng_valid only counts while a request is outstanding (at most one).
interface sonar_if #(
   parameter int NUM_CH = 4
) ();
   logic                   enable;
   logic [NUM_CH-1:0]      ch_mask;
   logic                   eng_measure;
   logic                   eng_valid;
   logic [15:0]            eng_ticks;
   logic [1:0]             ch_sel;
   logic [16*NUM_CH-1:0]   result;
   logic [NUM_CH-1:0]      fresh;
   logic [NUM_CH-1:0]      fresh_clr;
   logic [NUM_CH-1:0]      timeout_err;
   logic                   busy;

   modport master (
      output enable, ch_mask, eng_valid, eng_ticks, fresh_clr,
      input  eng_measure, ch_sel, result, fresh, timeout_err, busy
   );

   modport slave (
      input  enable, ch_mask, eng_valid, eng_ticks, fresh_clr,
      output eng_measure, ch_sel, result, fresh, timeout_err, busy
   );
endinterface

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ranging engine across NUM_CH channels,
// with settle, timeout and echo-decay guard intervals and per-channel result registers.
module sonar_scheduler #(
   parameter int NUM_CH         = 4,
   parameter int SETTLE_CYCLES  = 50,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int GUARD_CYCLES   = 3000000
) (
   input  logic       clk,
   input  logic       rst_n,
   sonar_if.slave     bus,
   output logic [2:0] dbg_state
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_SETTLE = 3'd2,
      S_START  = 3'd3,
      S_WAIT   = 3'd4,
      S_GUARD  = 3'd5
   } state_t;

   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] GUARD_LAST   = 32'(GUARD_CYCLES - 1);
   localparam logic [1:0]  LAST_CH      = 2'(NUM_CH - 1);

   state_t               state_q, state_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [1:0]           cur_q, cur_d;
   logic [1:0]           ch_sel_q, ch_sel_d;
   logic [16*NUM_CH-1:0] result_q, result_d;
   logic [NUM_CH-1:0]    fresh_q, fresh_d;
   logic [NUM_CH-1:0]    terr_q, terr_d;
   logic [NUM_CH-1:0]    set_fresh;
   logic                 eng_measure_q, eng_measure_d;
   logic                 busy_q, busy_d;
   logic [1:0]           next_ch, scan;
   logic                 found;

   // Upward search from cur+1; the last step lands back on cur, so cur wins only when alone.
   always_comb begin
      next_ch = cur_q;
      scan    = cur_q;
      found   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan = (scan == LAST_CH) ? 2'd0 : scan + 2'd1;
         if (!found && bus.ch_mask[scan]) begin
            next_ch = scan;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      ch_sel_d  = ch_sel_q;
      result_d  = result_q;
      terr_d    = terr_q;
      set_fresh = '0;
      unique case (state_q)
         S_IDLE: if (bus.enable && (|bus.ch_mask)) state_d = S_SELECT;
         S_SELECT: begin
            if (|bus.ch_mask) begin
               cur_d    = next_ch;
               ch_sel_d = next_ch;
               state_d  = S_SETTLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETTLE: if (cnt_q >= SETTLE_LAST) state_d = S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT: begin
            // A response in the final timeout cycle still counts as a good reading.
            if (bus.eng_valid) begin
               result_d[{ch_sel_q, 4'b0000} +: 16] = bus.eng_ticks;
               set_fresh[ch_sel_q] = 1'b1;
               terr_d[ch_sel_q]    = 1'b0;
               state_d             = S_GUARD;
            end else if (cnt_q >= TIMEOUT_LAST) begin
               result_d[{ch_sel_q, 4'b0000} +: 16] = 16'hFFFF;
               set_fresh[ch_sel_q] = 1'b1;
               terr_d[ch_sel_q]    = 1'b1;
               state_d             = S_GUARD;
            end
         end
         S_GUARD: if (cnt_q >= GUARD_LAST) state_d = bus.enable ? S_SELECT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      fresh_d       = (fresh_q & ~bus.fresh_clr) | set_fresh;
      cnt_d         = (state_d != state_q) ? 32'd0 : ((&cnt_q) ? cnt_q : cnt_q + 32'd1);
      eng_measure_d = (state_d == S_START);
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         cur_q         <= LAST_CH;
         ch_sel_q      <= '0;
         result_q      <= '0;
         fresh_q       <= '0;
         terr_q        <= '0;
         eng_measure_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cur_q         <= cur_d;
         ch_sel_q      <= ch_sel_d;
         result_q      <= result_d;
         fresh_q       <= fresh_d;
         terr_q        <= terr_d;
         eng_measure_q <= eng_measure_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.eng_measure = eng_measure_q;
   assign bus.ch_sel      = ch_sel_q;
   assign bus.result      = result_q;
   assign bus.fresh       = fresh_q;
   assign bus.timeout_err = terr_q;
   assign bus.busy        = busy_q;
   assign dbg_state       = state_q;
endmodule
